// File: rtl/apb_requester_multi.sv
// APB4 requester: commands are queued in a small FIFO and issued one at a time to
// NUM_SLV completers selected by the top SEL_W address bits; one response per command.
module apb_requester_multi #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_W   = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic                      cmd_write,
    input  logic [DATA_W-1:0]         cmd_wdata,
    input  logic [DATA_W/8-1:0]       cmd_strb,
    input  logic [2:0]                cmd_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    output logic [DATA_W/8-1:0]       pstrb,
    output logic [2:0]                pprot,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    logic [ADDR_W-1:0] r_mem_addr  [DEPTH];
    logic              r_mem_write [DEPTH];
    logic [DATA_W-1:0] r_mem_wdata [DEPTH];
    logic [STRB_W-1:0] r_mem_strb  [DEPTH];
    logic [2:0]        r_mem_prot  [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    state_t            r_state;
    logic [SEL_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_wait;

    logic              w_push;
    logic              w_pop;
    logic [PTR_W:0]    w_count_nxt;
    logic [SEL_W-1:0]  w_head_idx;
    logic              w_head_ok;
    logic [NUM_SLV-1:0] w_head_sel;
    logic              w_rdy;
    logic              w_err;
    logic [DATA_W-1:0] w_rdata;
    logic              w_to;

    assign w_push      = cmd_valid & cmd_ready;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_count_nxt = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    assign w_head_idx  = r_mem_addr[r_rd_ptr][ADDR_W-1 -: SEL_W];
    assign w_head_ok   = ({1'b0, w_head_idx} < (SEL_W+1)'(NUM_SLV));
    assign w_to        = TO_EN && (r_wait == TO_LAST);

    always_comb begin
        w_head_sel = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++)
            w_head_sel[i] = (w_head_idx == SEL_W'(i));
    end

    // Only the addressed completer's handshake is observed.
    always_comb begin
        w_rdy   = 1'b0;
        w_err   = 1'b0;
        w_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (r_idx == SEL_W'(i)) begin
                w_rdy   = pready[i];
                w_err   = pslverr[i];
                w_rdata = prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr]  <= cmd_addr;
            r_mem_write[r_wr_ptr] <= cmd_write;
            r_mem_wdata[r_wr_ptr] <= cmd_wdata;
            r_mem_strb[r_wr_ptr]  <= cmd_strb;
            r_mem_prot[r_wr_ptr]  <= cmd_prot;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_wait      <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= '0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count   <= w_count_nxt;
            cmd_ready <= (w_count_nxt != (PTR_W+1)'(DEPTH));

            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_idx  <= w_head_idx;
                        r_wait <= '0;
                        if (w_head_ok) begin
                            psel    <= w_head_sel;
                            paddr   <= r_mem_addr[r_rd_ptr];
                            pwrite  <= r_mem_write[r_rd_ptr];
                            pwdata  <= r_mem_wdata[r_rd_ptr];
                            pstrb   <= r_mem_write[r_rd_ptr] ? r_mem_strb[r_rd_ptr] : '0;
                            pprot   <= r_mem_prot[r_rd_ptr];
                            r_state <= S_SETUP;
                        end else begin
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_SETUP: begin
                    penable <= 1'b1;
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_rdy) begin
                        psel        <= '0;
                        penable     <= 1'b0;
                        rsp_rdata   <= (pwrite || w_err) ? '0 : w_rdata;
                        rsp_err     <= w_err;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_to) begin
                        psel        <= '0;
                        penable     <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
